method_arb: RTL and testbench

METHOD_ARB -- requirements
Module: method_arb

---
 rtl/method_arb_pkg.sv | 13 +
 rtl/method_arb_rr_picker.sv | 28 ++
 rtl/method_arb.sv | 95 +++++++++
 tb/tb_method_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/method_arb_pkg.sv
// Shared constants and the hold-register type for the method arbiter.
package method_arb_pkg;
  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;
  localparam int ID_W     = $clog2(NREQ_DEF);
  localparam int CNT_W    = 16;

  typedef struct packed {
    logic [W_DEF-1:0] in1;
    logic [W_DEF-1:0] in2;
    logic [ID_W-1:0]  src;
  } hold_t;
endpackage

// File: rtl/method_arb_rr_picker.sv
// Combinational round-robin picker: first set req at or after ptr, cyclically.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);
  int idx;

  // Walk from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    grant = '0;
    id    = '0;
    idx   = 0;
    for (int off = NREQ-1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/method_arb.sv
// Round-robin arbiter feeding a single-entry hold register into an action method.
// Optional counters enabled by METHOD_ARB_STATS_EN.
module method_arb
  import method_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_in1,
  input  logic [NREQ*W-1:0] req_in2,
  output logic [NREQ-1:0]   grant,
  input  logic            RDY_method1,
  output logic            EN_method1,
  output logic [W-1:0]    method1_in1,
  output logic [W-1:0]    method1_in2,
  output logic [IDW-1:0]  last_src
`ifdef METHOD_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]   stat_sel,
  output logic [CNT_W-1:0] stat_grants,
  output logic [CNT_W-1:0] stat_stalls
`endif
);
  typedef struct packed {
    logic [W-1:0]   in1;
    logic [W-1:0]   in2;
    logic [IDW-1:0] src;
  } hold_w_t;

  hold_w_t         hold_q;
  logic            full_q;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_id;
  logic            can_acc;
  logic [W-1:0]    sel_in1, sel_in2;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .id    (pick_id)
  );

  assign EN_method1  = full_q & RDY_method1;
  assign can_acc     = ~full_q | EN_method1;
  // Gate with RST so the grant drops the instant reset is asserted.
  assign grant       = (RST || !can_acc) ? '0 : pick_oh;
  assign method1_in1 = full_q ? hold_q.in1 : '0;
  assign method1_in2 = full_q ? hold_q.in2 : '0;
  assign sel_in1     = req_in1[int'(pick_id)*W +: W];
  assign sel_in2     = req_in2[int'(pick_id)*W +: W];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q   <= '0;
      full_q   <= 1'b0;
      rr_ptr   <= '0;
      last_src <= '0;
    end else begin
      if (EN_method1) last_src <= hold_q.src;
      if (|grant) begin
        hold_q <= '{in1: sel_in1, in2: sel_in2, src: pick_id};
        full_q <= 1'b1;
        rr_ptr <= (pick_id == IDW'(NREQ-1)) ? '0 : pick_id + 1'b1;
      end else if (EN_method1) begin
        hold_q <= '0;
        full_q <= 1'b0;
      end
    end
  end

`ifdef METHOD_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt [NREQ];
  logic [CNT_W-1:0] scnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) gcnt[i] <= '0;
      scnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (grant[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 1'b1;
      if (full_q && !RDY_method1 && scnt != '1) scnt <= scnt + 1'b1;
    end
  end

  assign stat_grants = (int'(stat_sel) < NREQ) ? gcnt[stat_sel] : '0;
  assign stat_stalls = scnt;
`endif
endmodule

// File: tb/tb_method_arb.sv
// Self-checking bench for method_arb: directed scenarios plus randomized traffic vs. a model.
module tb_method_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_in1, req_in2;
  logic [N-1:0]   grant;
  logic           RDY_method1;
  logic           EN_method1;
  logic [W-1:0]   method1_in1, method1_in2;
  logic [1:0]     last_src;
`ifdef METHOD_ARB_STATS_EN
  logic [1:0]     stat_sel;
  logic [15:0]    stat_grants, stat_stalls;
`endif

  int tests = 0;
  int fails = 0;

  method_arb #(.NREQ(N), .W(W)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_in1(req_in1), .req_in2(req_in2),
    .grant(grant), .RDY_method1(RDY_method1), .EN_method1(EN_method1),
    .method1_in1(method1_in1), .method1_in2(method1_in2), .last_src(last_src)
`ifdef METHOD_ARB_STATS_EN
    , .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural model: one optional pending payload plus a rotating priority start.
  bit          m_full;
  int          m_in1, m_in2, m_src, m_ptr, m_last, m_win;
  int          m_stalls;
  logic [N-1:0] exp_grant;
  bit          exp_en;
  logic [W-1:0] exp_in1, exp_in2;

  task automatic model_reset();
    m_full = 0; m_in1 = 0; m_in2 = 0; m_src = 0; m_ptr = 0; m_last = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    bit acc;
    exp_en    = m_full && RDY_method1;
    acc       = !m_full || exp_en;
    exp_grant = '0;
    m_win     = -1;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c] && m_win < 0) m_win = c;
      end
      if (m_win >= 0) exp_grant[m_win] = 1'b1;
    end
    exp_in1 = m_full ? W'(m_in1) : '0;
    exp_in2 = m_full ? W'(m_in2) : '0;
  endtask

  task automatic model_commit();
    if (m_full && !RDY_method1) m_stalls++;
    if (exp_en) m_last = m_src;
    if (m_win >= 0) begin
      m_in1  = int'(req_in1[m_win*W +: W]);
      m_in2  = int'(req_in2[m_win*W +: W]);
      m_src  = m_win;
      m_full = 1;
      m_ptr  = (m_win + 1) % N;
    end else if (exp_en) m_full = 0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic set_arg(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask

  task automatic do_reset();
    RST = 1'b1; req = '0; RDY_method1 = 1'b0; req_in1 = '0; req_in2 = '0;
`ifdef METHOD_ARB_STATS_EN
    stat_sel = '0;
`endif
    tick(); tick();
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    RDY_method1 = 1'b1; #1;
    tests++; if (grant !== '0)        begin fails++; $display("FAIL reset_grant got=%b exp=0", grant); end
    tests++; if (EN_method1 !== 1'b0) begin fails++; $display("FAIL reset_en got=%b exp=0", EN_method1); end
    tests++; if (method1_in1 !== '0 || method1_in2 !== '0)
      begin fails++; $display("FAIL reset_args got=%h/%h exp=0/0", method1_in1, method1_in2); end
    tests++; if (last_src !== 2'd0)   begin fails++; $display("FAIL reset_last got=%0d exp=0", last_src); end
  endtask

  task automatic test_single_issue();
    do_reset();
    req = 4'b0100; set_arg(2, 32'd5, 32'd7); RDY_method1 = 1'b1; #1;
    tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant got=%b exp=0100", grant); end
    tick(); req = '0; #1;
    tests++; if (EN_method1 !== 1'b1 || method1_in1 !== 32'd5 || method1_in2 !== 32'd7)
      begin fails++; $display("FAIL single_issue got en=%b %0d/%0d exp en=1 5/7", EN_method1, method1_in1, method1_in2); end
    tick();
    tests++; if (last_src !== 2'd2) begin fails++; $display("FAIL single_last got=%0d exp=2", last_src); end
    tests++; if (EN_method1 !== 1'b0) begin fails++; $display("FAIL single_drain got=%b exp=0", EN_method1); end
  endtask

  task automatic test_fairness();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    req = 4'b1111; RDY_method1 = 1'b1;
    for (int i = 0; i < N; i++) set_arg(i, W'(i + 10), W'(i + 20));
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] want;
      #1;
      want = '0; want[order[c]] = 1'b1;
      tests++; if (grant !== want) begin fails++; $display("FAIL fair_c%0d got=%b exp=%b", c, grant, want); end
      tick();
    end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0] held1, held2;
    do_reset();
    set_arg(0, 32'hA0A0_0001, 32'hB0B0_0001);
    set_arg(1, 32'hA0A0_0002, 32'hB0B0_0002);
    req = 4'b0011; RDY_method1 = 1'b1; #1;
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL bp_first got=%b exp=0001", grant); end
    tick();
    RDY_method1 = 1'b0;
    held1 = 32'hA0A0_0001; held2 = 32'hB0B0_0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (grant !== '0 || EN_method1 !== 1'b0 || method1_in1 !== held1 || method1_in2 !== held2)
        begin fails++; $display("FAIL bp_stall_c%0d got g=%b en=%b %h/%h", c, grant, EN_method1, method1_in1, method1_in2); end
      tick();
    end
    RDY_method1 = 1'b1; #1;
    tests++; if (EN_method1 !== 1'b1 || grant !== 4'b0010)
      begin fails++; $display("FAIL bp_release got en=%b g=%b exp en=1 g=0010", EN_method1, grant); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; set_arg(2, 32'd99, 32'd98); RDY_method1 = 1'b0; #1;
    tick();
    req = 4'b0011; RDY_method1 = 1'b1; RST = 1'b1; #1;
    tests++; if (EN_method1 !== 1'b0 || grant !== '0 || method1_in1 !== '0 || last_src !== 2'd0)
      begin fails++; $display("FAIL rstmid_hold got en=%b g=%b in1=%h last=%0d", EN_method1, grant, method1_in1, last_src); end
    tick();
    RST = 1'b0; model_reset();
    req = 4'b0110; #1;
    tests++; if (EN_method1 !== 1'b0 || grant !== 4'b0010)
      begin fails++; $display("FAIL rstmid_first got en=%b g=%b exp en=0 g=0010", EN_method1, grant); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) set_arg(i, $urandom, $urandom);
      RDY_method1 = ($urandom_range(0, 9) < 7);
      #1;
      model_eval();
      tests++; if (grant !== exp_grant) begin fails++; $display("FAIL rand_grant c%0d got=%b exp=%b", c, grant, exp_grant); end
      tests++; if (EN_method1 !== exp_en) begin fails++; $display("FAIL rand_en c%0d got=%b exp=%b", c, EN_method1, exp_en); end
      tests++; if (method1_in1 !== exp_in1 || method1_in2 !== exp_in2)
        begin fails++; $display("FAIL rand_args c%0d got=%h/%h exp=%h/%h", c, method1_in1, method1_in2, exp_in1, exp_in2); end
      tests++; if (last_src !== 2'(m_last)) begin fails++; $display("FAIL rand_last c%0d got=%0d exp=%0d", c, last_src, m_last); end
      model_commit();
      tick();
    end
  endtask

`ifdef METHOD_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    req = 4'b0010; set_arg(1, 32'd1, 32'd2);
    for (int c = 0; c < 70010; c++) begin
      RDY_method1 = !(c >= 5 && c < 9);
      #1; model_eval(); model_commit(); tick();
    end
    req = '0; stat_sel = 2'd1; #1;
    tests++; if (stat_grants !== 16'hFFFF) begin fails++; $display("FAIL stat_grants got=%h exp=ffff", stat_grants); end
    tests++; if (stat_stalls !== 16'(m_stalls)) begin fails++; $display("FAIL stat_stalls got=%0d exp=%0d", stat_stalls, m_stalls); end
    stat_sel = 2'd0; #1;
    tests++; if (stat_grants !== 16'd0) begin fails++; $display("FAIL stat_sel0 got=%h exp=0", stat_grants); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_issue();
    test_fairness();
    test_back_pressure();
    test_reset_mid();
    test_random();
`ifdef METHOD_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
